password_lock_fsm: RTL and testbench

- Parametrised successor of the single-code button lock. Accepts a CODE_LEN-symbol sequence from four direction buttons and compares it against a code register.
- Adds three things: a retry limit with timed lockout, an entry timeout, and code reprogramming allowed only while unlocked.
- Sits between the per-button edge detectors (one-cycle pulses) and the board 7-segment display.

---
 rtl/password_lock_fsm.sv | 242 ++++++++++++++++++++++++
 tb/tb_password_lock_fsm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/password_lock_fsm.sv
// Four-button code lock with retry limit, timed lockout, entry timeout and
// code reprogramming while unlocked. Drives a single 7-segment digit.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   btn_pulse[3:0]    : one-cycle press pulses, bit0=U bit1=D bit2=L bit3=R
//   prog_mode         : level, request to reprogram (honoured in UNLOCKED)
//   relock            : pulse, leave UNLOCKED
//   state_o[2:0]      : IDLE=0 ENTRY=1 UNLOCKED=2 FAIL=3 LOCKED=4 PROG=5
//   unlocked, locked  : state flags
//   progress[3:0]     : symbols accepted in the current ENTRY/PROG sequence
//   tries_left[2:0]   : attempts remaining before lockout
//   seg_d[6:0]        : active-low gfedcba segments
//   seg_an[3:0]       : digit enables, only digit 0 active
module password_lock_fsm #(
    parameter int unsigned             CODE_LEN       = 4,
    parameter logic [2*CODE_LEN-1:0]   DEFAULT_CODE   = (2*CODE_LEN)'(8'b11_10_10_00),
    parameter int unsigned             MAX_TRIES      = 3,
    parameter int unsigned             LOCK_CYCLES    = 100000000,
    parameter int unsigned             TIMEOUT_CYCLES = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_pulse,
    input  logic       prog_mode,
    input  logic       relock,
    output logic [2:0] state_o,
    output logic       unlocked,
    output logic       locked,
    output logic [3:0] progress,
    output logic [2:0] tries_left,
    output logic [6:0] seg_d,
    output logic [3:0] seg_an
);

    localparam int unsigned CW  = 2 * CODE_LEN;
    localparam int unsigned TW  = 32;
    localparam int unsigned PW  = 4;
    localparam int unsigned TRW = 3;

    localparam logic [TW-1:0]  TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]  LOCK_LOAD    = TW'(LOCK_CYCLES - 1);
    localparam logic [TRW-1:0] TRIES_FULL   = TRW'(MAX_TRIES);
    localparam logic [PW-1:0]  LAST_POS     = PW'(CODE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTRY    = 3'd1,
        S_UNLOCKED = 3'd2,
        S_FAIL     = 3'd3,
        S_LOCKED   = 3'd4,
        S_PROG     = 3'd5
    } state_t;

    state_t          state_q, state_n;
    logic [PW-1:0]   progress_q, progress_n;
    logic            err_q, err_n;
    logic [TW-1:0]   timer_q, timer_n;
    logic [CW-1:0]   code_q, code_n;
    logic [CW-1:0]   shadow_q, shadow_n;
    logic [TRW-1:0]  tries_q, tries_n;

    logic            press;
    logic            valid;
    logic [1:0]      sym;
    logic [CW-1:0]   code_shift;
    logic [1:0]      exp_sym;
    logic            mismatch;
    logic [CW-1:0]   shadow_wr;
    logic [2:0]      idx;

    // Segment pattern for a given state/progress (active-low gfedcba)
    function automatic logic [6:0] seg_for(input state_t s, input logic [PW-1:0] p);
        logic [6:0] r;
        r = 7'b1000000;
        case (s)
            S_ENTRY: begin
                case (p)
                    4'd1:    r = 7'b1111001;
                    4'd2:    r = 7'b0100100;
                    4'd3:    r = 7'b0110000;
                    4'd4:    r = 7'b0011001;
                    4'd5:    r = 7'b0010010;
                    4'd6:    r = 7'b0000010;
                    4'd7:    r = 7'b1111000;
                    default: r = 7'b1000000;
                endcase
            end
            S_UNLOCKED: r = 7'b0010000;
            S_FAIL:     r = 7'b0000110;
            S_LOCKED:   r = 7'b1000111;
            S_PROG:     r = 7'b0001100;
            default:    r = 7'b1000000;
        endcase
        return r;
    endfunction

    // Button decode and compare against the code symbol at the current position
    always_comb begin
        press = |btn_pulse;
        valid = $onehot(btn_pulse);
        sym   = 2'd0;
        if (btn_pulse[1]) sym = 2'd1;
        if (btn_pulse[2]) sym = 2'd2;
        if (btn_pulse[3]) sym = 2'd3;
        idx        = progress_q[2:0];
        code_shift = code_q >> {idx, 1'b0};
        exp_sym    = code_shift[1:0];
        mismatch   = !valid || (sym != exp_sym);
        shadow_wr  = (shadow_q & ~(CW'(2'b11) << {idx, 1'b0})) | (CW'(sym) << {idx, 1'b0});
    end

    // Next-state and datapath update
    always_comb begin
        state_n    = state_q;
        progress_n = progress_q;
        err_n      = err_q;
        timer_n    = timer_q;
        code_n     = code_q;
        shadow_n   = shadow_q;
        tries_n    = tries_q;

        case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_n    = S_ENTRY;
                    progress_n = 4'd1;
                    err_n      = mismatch;
                    timer_n    = TIMEOUT_LOAD;
                end
            end
            S_ENTRY: begin
                if (press) begin
                    timer_n = TIMEOUT_LOAD;
                    if (progress_q == LAST_POS) begin
                        // Verdict uses the accumulated error including this press
                        progress_n = 4'd0;
                        err_n      = 1'b0;
                        if (!(err_q || mismatch)) begin
                            state_n = S_UNLOCKED;
                            tries_n = TRIES_FULL;
                        end else if (tries_q > 3'd1) begin
                            state_n = S_FAIL;
                            tries_n = tries_q - 3'd1;
                        end else begin
                            state_n = S_LOCKED;
                            tries_n = 3'd0;
                            timer_n = LOCK_LOAD;
                        end
                    end else begin
                        progress_n = progress_q + 4'd1;
                        err_n      = err_q | mismatch;
                    end
                end else if (timer_q == '0) begin
                    state_n    = S_IDLE;
                    progress_n = 4'd0;
                    err_n      = 1'b0;
                end else begin
                    timer_n = timer_q - 32'd1;
                end
            end
            S_FAIL: begin
                if (press) state_n = S_IDLE;
            end
            S_LOCKED: begin
                if (timer_q == '0) begin
                    state_n = S_IDLE;
                    tries_n = TRIES_FULL;
                end else begin
                    timer_n = timer_q - 32'd1;
                end
            end
            S_UNLOCKED: begin
                if (relock) begin
                    state_n = S_IDLE;
                end else if (prog_mode) begin
                    state_n    = S_PROG;
                    progress_n = 4'd0;
                    timer_n    = TIMEOUT_LOAD;
                end
            end
            S_PROG: begin
                if (!prog_mode || (press && !valid)) begin
                    state_n    = S_UNLOCKED;
                    progress_n = 4'd0;
                end else if (press) begin
                    shadow_n = shadow_wr;
                    timer_n  = TIMEOUT_LOAD;
                    if (progress_q == LAST_POS) begin
                        code_n     = shadow_wr;
                        state_n    = S_IDLE;
                        progress_n = 4'd0;
                    end else begin
                        progress_n = progress_q + 4'd1;
                    end
                end else if (timer_q == '0) begin
                    state_n    = S_UNLOCKED;
                    progress_n = 4'd0;
                end else begin
                    timer_n = timer_q - 32'd1;
                end
            end
            default: begin
                state_n    = S_IDLE;
                progress_n = 4'd0;
                err_n      = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            progress_q <= 4'd0;
            err_q      <= 1'b0;
            timer_q    <= '0;
            code_q     <= DEFAULT_CODE;
            shadow_q   <= DEFAULT_CODE;
            tries_q    <= TRIES_FULL;
            unlocked   <= 1'b0;
            locked     <= 1'b0;
            seg_d      <= 7'b1000000;
        end else begin
            state_q    <= state_n;
            progress_q <= progress_n;
            err_q      <= err_n;
            timer_q    <= timer_n;
            code_q     <= code_n;
            shadow_q   <= shadow_n;
            tries_q    <= tries_n;
            unlocked   <= (state_n == S_UNLOCKED);
            locked     <= (state_n == S_LOCKED);
            seg_d      <= seg_for(state_n, progress_n);
        end
    end

    assign state_o    = state_q;
    assign progress   = progress_q;
    assign tries_left = tries_q;
    assign seg_an     = 4'b1110;

endmodule

// File: tb/tb_password_lock_fsm.sv
// Directed bench for password_lock_fsm (CODE_LEN=4, LOCK=20, TIMEOUT=50).
module tb_password_lock_fsm;

    localparam logic [3:0] U = 4'b0001;
    localparam logic [3:0] D = 4'b0010;
    localparam logic [3:0] L = 4'b0100;
    localparam logic [3:0] R = 4'b1000;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_L = 7'b1000111;
    localparam logic [6:0] SEG_P = 7'b0001100;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_pulse;
    logic       prog_mode;
    logic       relock;
    logic [2:0] state_o;
    logic       unlocked;
    logic       locked;
    logic [3:0] progress;
    logic [2:0] tries_left;
    logic [6:0] seg_d;
    logic [3:0] seg_an;

    int vectors     = 0;
    int miscompares = 0;

    password_lock_fsm #(
        .CODE_LEN       (4),
        .LOCK_CYCLES    (20),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_pulse  (btn_pulse),
        .prog_mode  (prog_mode),
        .relock     (relock),
        .state_o    (state_o),
        .unlocked   (unlocked),
        .locked     (locked),
        .progress   (progress),
        .tries_left (tries_left),
        .seg_d      (seg_d),
        .seg_an     (seg_an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input logic [3:0] b);
        btn_pulse = b;
        tick();
        btn_pulse = 4'b0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wrong_seq();
        press(D); press(D); press(D); press(D);
    endtask

    initial begin
        reset     = 1'b1;
        btn_pulse = 4'b0000;
        prog_mode = 1'b0;
        relock    = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_progress", 32'(progress), 32'd0);
        chk("rst_tries", 32'(tries_left), 32'd3);
        chk("rst_seg", 32'(seg_d), 32'(SEG_0));
        chk("rst_flags", 32'({unlocked, locked}), 32'd0);
        chk("seg_an", 32'(seg_an), 32'hE);
        reset = 1'b0;

        // 1: correct code U,L,L,R with 3-cycle spacing
        press(U);
        chk("t1_state1", 32'(state_o), 32'd1);
        chk("t1_prog1", 32'(progress), 32'd1);
        chk("t1_seg1", 32'(seg_d), 32'(SEG_1));
        idle(2);
        press(L);
        chk("t1_prog2", 32'(progress), 32'd2);
        idle(2);
        press(L);
        chk("t1_prog3", 32'(progress), 32'd3);
        chk("t1_seg3", 32'(seg_d), 32'(SEG_3));
        idle(2);
        press(R);
        chk("t1_state_unl", 32'(state_o), 32'd2);
        chk("t1_unlocked", 32'(unlocked), 32'd1);
        chk("t1_seg9", 32'(seg_d), 32'(SEG_9));
        chk("t1_tries", 32'(tries_left), 32'd3);
        relock = 1'b1;
        tick();
        relock = 1'b0;
        chk("t1_relock", 32'(state_o), 32'd0);

        // 2: wrong second symbol -> FAIL, next press -> IDLE
        press(U); press(D); press(L); press(R);
        chk("t2_fail", 32'(state_o), 32'd3);
        chk("t2_tries", 32'(tries_left), 32'd2);
        chk("t2_segE", 32'(seg_d), 32'(SEG_E));
        press(U);
        chk("t2_idle", 32'(state_o), 32'd0);

        // 3: three failures -> LOCKED for exactly 20 cycles
        do_reset();
        wrong_seq();
        chk("t3_fail1", 32'(tries_left), 32'd2);
        press(U);
        wrong_seq();
        chk("t3_fail2", 32'(tries_left), 32'd1);
        press(U);
        wrong_seq();
        chk("t3_locked", 32'(state_o), 32'd4);
        chk("t3_tries0", 32'(tries_left), 32'd0);
        chk("t3_lockflag", 32'(locked), 32'd1);
        chk("t3_segL", 32'(seg_d), 32'(SEG_L));
        press(U);
        chk("t3_ignored", 32'(state_o), 32'd4);
        idle(17);
        press(R);
        chk("t3_cyc19", 32'(state_o), 32'd4);
        tick();
        chk("t3_cyc20", 32'(state_o), 32'd0);
        chk("t3_tries_rel", 32'(tries_left), 32'd3);
        chk("t3_unlockflag", 32'(locked), 32'd0);

        // 4: entry timeout after 50 idle cycles, then invalid first symbol
        press(U);
        idle(49);
        chk("t4_before_to", 32'(state_o), 32'd1);
        tick();
        chk("t4_timeout", 32'(state_o), 32'd0);
        chk("t4_tries", 32'(tries_left), 32'd3);
        chk("t4_prog0", 32'(progress), 32'd0);
        idle(10);
        press(U | L);
        chk("t4_multi_entry", 32'(state_o), 32'd1);
        press(L); press(L); press(R);
        chk("t4_multi_fail", 32'(state_o), 32'd3);
        chk("t4_multi_tries", 32'(tries_left), 32'd2);
        press(U);

        // 5: reprogram to D,D,R,R
        press(U); press(L); press(L); press(R);
        chk("t5_unl", 32'(state_o), 32'd2);
        chk("t5_tries_rel", 32'(tries_left), 32'd3);
        prog_mode = 1'b1;
        tick();
        chk("t5_prog", 32'(state_o), 32'd5);
        chk("t5_segP", 32'(seg_d), 32'(SEG_P));
        press(D); press(D);
        chk("t5_prog2", 32'(progress), 32'd2);
        press(R); press(R);
        chk("t5_written", 32'(state_o), 32'd0);
        prog_mode = 1'b0;
        press(D); press(D); press(R); press(R);
        chk("t5_new_code", 32'(state_o), 32'd2);
        relock = 1'b1;
        tick();
        relock = 1'b0;
        press(U); press(L); press(L); press(R);
        chk("t5_old_fails", 32'(state_o), 32'd3);
        press(U);
        press(D); press(D); press(R); press(R);
        chk("t5_unl2", 32'(state_o), 32'd2);
        prog_mode = 1'b1;
        tick();
        press(U); press(U);
        prog_mode = 1'b0;
        tick();
        chk("t5_abort", 32'(state_o), 32'd2);
        relock = 1'b1;
        tick();
        relock = 1'b0;
        press(D); press(D); press(R); press(R);
        chk("t5_code_kept", 32'(state_o), 32'd2);
        relock = 1'b1;
        tick();
        relock = 1'b0;

        // 6: reset mid-ENTRY and mid-LOCKED
        press(U); press(L);
        chk("t6_mid_entry", 32'(progress), 32'd2);
        do_reset();
        chk("t6_r1_state", 32'(state_o), 32'd0);
        chk("t6_r1_prog", 32'(progress), 32'd0);
        chk("t6_r1_tries", 32'(tries_left), 32'd3);
        chk("t6_r1_seg", 32'(seg_d), 32'(SEG_0));
        wrong_seq(); press(U);
        wrong_seq(); press(U);
        wrong_seq();
        chk("t6_locked", 32'(state_o), 32'd4);
        idle(3);
        do_reset();
        chk("t6_r2_state", 32'(state_o), 32'd0);
        chk("t6_r2_tries", 32'(tries_left), 32'd3);
        chk("t6_r2_lock", 32'(locked), 32'd0);
        press(U); press(L); press(L); press(R);
        chk("t6_default_code", 32'(state_o), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
